// File: rtl/p_frame_fifo.sv
// rtl/p_frame_fifo.sv - frame-granular FIFO between pooling and conv layers.
// Define P_FRAME_FIFO_LEVEL_EN to expose level/frames_stored debug outputs.
module p_frame_fifo #(
    parameter int CH        = 6,
    parameter int DW        = 16,
    parameter int FRAME_LEN = 144,
    parameter int DEPTH     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH*DW-1:0]        din,
    input  logic                    din_valid,
    input  logic                    out_ready,
    output logic [CH*DW-1:0]        dout,
    output logic                    dout_valid,
    output logic                    dout_last,
    output logic                    frame_avail,
    output logic                    overflow
`ifdef P_FRAME_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level,
    output logic [$clog2(DEPTH):0]  frames_stored
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = CH * DW;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] A_ONE    = AW'(1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    logic [WW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d, frames_q, frames_d;
    logic [WW-1:0] dout_q;
    logic          dout_valid_q, dout_last_q, frame_avail_q, overflow_q;
    logic          rd_en, wr_en, frame_done, rd_last;

    always_comb begin
        rd_en      = (state_q == STREAM) && out_ready;
        // A full FIFO still takes a word when the oldest one leaves this cycle.
        wr_en      = din_valid && ((count_q != FULL) || rd_en);
        frame_done = wr_en && (wr_idx_q == LAST_IDX);
        rd_last    = rd_en && (rd_idx_q == LAST_IDX);

        wr_ptr_d = wr_en ? wr_ptr_q + A_ONE : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + A_ONE : rd_ptr_q;
        wr_idx_d = wr_idx_q;
        if (wr_en) wr_idx_d = frame_done ? '0 : wr_idx_q + A_ONE;
        rd_idx_d = rd_idx_q;
        if (rd_en) rd_idx_d = rd_last ? '0 : rd_idx_q + A_ONE;

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
        case ({frame_done, rd_last})
            2'b10:   frames_d = frames_q + C_ONE;
            2'b01:   frames_d = frames_q - C_ONE;
            default: frames_d = frames_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frames_q != '0) state_d = STREAM;
            STREAM:  if (rd_last && (frames_d == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            count_q       <= '0;
            frames_q      <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_last_q   <= 1'b0;
            frame_avail_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            count_q       <= count_d;
            frames_q      <= frames_d;
            if (rd_en) dout_q <= mem[rd_ptr_q];
            dout_valid_q  <= rd_en;
            dout_last_q   <= rd_last;
            frame_avail_q <= (frames_d != '0);
            if (din_valid && !wr_en) overflow_q <= 1'b1;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_last   = dout_last_q;
    assign frame_avail = frame_avail_q;
    assign overflow    = overflow_q;
`ifdef P_FRAME_FIFO_LEVEL_EN
    assign level         = count_q;
    assign frames_stored = frames_q;
`endif
endmodule

// File: tb/tb_p_frame_fifo.sv
// tb/tb_p_frame_fifo.sv - directed self-checking bench for p_frame_fifo.
module tb_p_frame_fifo;
    localparam int CH = 6, DW = 16, FL = 144, DEPTH = 256, WW = CH * DW;

    logic          clk = 1'b0, rst = 1'b1, din_valid = 1'b0, out_ready = 1'b0;
    logic [WW-1:0] din = '0;
    logic [WW-1:0] dout;
    logic          dout_valid, dout_last, frame_avail, overflow;

    p_frame_fifo #(.CH(CH), .DW(DW), .FRAME_LEN(FL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .out_ready(out_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .frame_avail(frame_avail), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    logic [WW-1:0] q_data[$];
    logic          q_last[$];
    int            q_cyc[$];

    always @(negedge clk) begin
        if (dout_valid) begin
            q_data.push_back(dout);
            q_last.push_back(dout_last);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [WW-1:0] mk(input int n);
        logic [WW-1:0] w;
        for (int k = 0; k < CH; k++) w[k*DW +: DW] = 16'(n * 8 + k);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic wr(input int n);
        din = mk(n);
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, output bit ok);
        int b = 0;
        while (q_data.size() < n && b < 2000) begin
            step();
            b++;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({dout_valid, dout_last, frame_avail, overflow} !== 4'b0000 || dout !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b l=%b fa=%b ov=%b d=%h, want all 0",
                     dout_valid, dout_last, frame_avail, overflow, dout);
        end
    endtask

    task automatic test_single_frame();
        int wcyc;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            wr(i);
            if (i == FL - 2) begin
                n_cmp++;
                if (frame_avail !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_avail_early: got %b want 0", frame_avail);
                end
            end
        end
        wcyc = cyc;
        n_cmp++;
        if (frame_avail !== 1'b1) begin
            n_bad++;
            $display("FAIL single_avail_rise: got %b want 1", frame_avail);
        end
        wait_q(FL, ok);
        repeat (5) step();
        n_cmp++;
        if (!ok || q_data.size() != FL) begin
            n_bad++;
            $display("FAIL single_count: got %0d pulses want %0d", q_data.size(), FL);
        end
        n_cmp++;
        if (q_cyc.size() > 0 && q_cyc[0] != wcyc + 2) begin
            n_bad++;
            $display("FAIL single_latency: first pulse cycle %0d want %0d", q_cyc[0], wcyc + 2);
        end
        for (int i = 0; i < q_data.size() && i < FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(i) || q_last[i] !== (i == FL - 1)) begin
                n_bad++;
                $display("FAIL single_word[%0d]: got %h last=%b want %h last=%b",
                         i, q_data[i], q_last[i], mk(i), (i == FL - 1));
            end
        end
        n_cmp++;
        if (dut.frames_q !== '0 || dut.count_q !== '0 || frame_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drained: frames=%0d count=%0d fa=%b want 0/0/0",
                     dut.frames_q, dut.count_q, frame_avail);
        end
    endtask

    task automatic test_toggle();
        int b = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            out_ready = ~out_ready;
            wr(i);
        end
        while (q_data.size() < FL && b < 2000) begin
            out_ready = ~out_ready;
            step();
            b++;
        end
        repeat (6) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b0;
        n_cmp++;
        if (q_data.size() != FL) begin
            n_bad++;
            $display("FAIL toggle_count: got %0d pulses want %0d", q_data.size(), FL);
        end
        for (int i = 0; i < q_data.size() && i < FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(i) || q_last[i] !== (i == FL - 1) ||
                (i > 0 && q_cyc[i] - q_cyc[i-1] != 2)) begin
                n_bad++;
                $display("FAIL toggle_word[%0d]: got %h last=%b cyc=%0d want %h last=%b spacing 2",
                         i, q_data[i], q_last[i], q_cyc[i], mk(i), (i == FL - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * FL; i++) wr(i);
        n_cmp++;
        if (q_data.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_overlap: got 0 pulses during writes want >0");
        end
        wait_q(2 * FL, ok);
        repeat (5) step();
        n_cmp++;
        if (!ok || q_data.size() != 2 * FL) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d pulses want %0d", q_data.size(), 2 * FL);
        end
        for (int i = 0; i < q_data.size() && i < 2 * FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(i) || q_last[i] !== (i == FL - 1 || i == 2 * FL - 1) ||
                q_cyc[i] != q_cyc[0] + i) begin
                n_bad++;
                $display("FAIL b2b_word[%0d]: got %h last=%b cyc=%0d want %h cyc=%0d",
                         i, q_data[i], q_last[i], q_cyc[i], mk(i), q_cyc[0] + i);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            wr(i);
            if (i == DEPTH - 1) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_early: got %b want 0", overflow);
                end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1 || dut.count_q !== 9'd256 || dut.frames_q !== 9'd1 ||
            frame_avail !== 1'b1 || q_data.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_state: ov=%b count=%0d frames=%0d fa=%b pulses=%0d want 1/256/1/1/0",
                     overflow, dut.count_q, dut.frames_q, frame_avail, q_data.size());
        end
        out_ready = 1'b1;
        wait_q(FL, ok);
        repeat (5) step();
        n_cmp++;
        if (!ok || q_data.size() != FL || dut.count_q !== 9'd112 || dut.frames_q !== '0 ||
            overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_drain: pulses=%0d count=%0d frames=%0d ov=%b want 144/112/0/1",
                     q_data.size(), dut.count_q, dut.frames_q, overflow);
        end
        for (int i = 0; i < q_data.size() && i < FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(i)) begin
                n_bad++;
                $display("FAIL ovf_f1[%0d]: got %h want %h", i, q_data[i], mk(i));
            end
        end
        clear_q();
        for (int i = 0; i < 32; i++) wr(300 + i);
        wait_q(FL, ok);
        repeat (5) step();
        n_cmp++;
        if (!ok || q_data.size() != FL) begin
            n_bad++;
            $display("FAIL ovf_f2_count: got %0d pulses want %0d", q_data.size(), FL);
        end
        for (int i = 0; i < q_data.size() && i < FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(i < 112 ? FL + i : 300 + i - 112) || q_last[i] !== (i == FL - 1)) begin
                n_bad++;
                $display("FAIL ovf_f2[%0d]: got %h last=%b want %h", i, q_data[i], q_last[i],
                         mk(i < 112 ? FL + i : 300 + i - 112));
            end
        end
    endtask

    task automatic test_partial();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) wr(i);
        repeat (20) step();
        n_cmp++;
        if (q_data.size() != 0 || frame_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_hold: pulses=%0d fa=%b want 0/0", q_data.size(), frame_avail);
        end
        for (int i = 100; i < FL; i++) wr(i);
        wait_q(FL, ok);
        repeat (5) step();
        n_cmp++;
        if (!ok || q_data.size() != FL) begin
            n_bad++;
            $display("FAIL partial_count: got %0d pulses want %0d", q_data.size(), FL);
        end
        for (int i = 0; i < q_data.size() && i < FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(i) || q_last[i] !== (i == FL - 1)) begin
                n_bad++;
                $display("FAIL partial_word[%0d]: got %h want %h", i, q_data[i], mk(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < FL; i++) wr(i);
        wait_q(50, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rstmid_reach: got %0d pulses want 50", q_data.size());
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({dout_valid, dout_last, frame_avail, overflow} !== 4'b0000 || dout !== '0 ||
            dut.count_q !== '0 || dut.frames_q !== '0) begin
            n_bad++;
            $display("FAIL rstmid_clear: v=%b l=%b fa=%b ov=%b d=%h count=%0d, want all 0",
                     dout_valid, dout_last, frame_avail, overflow, dout, dut.count_q);
        end
        rst = 1'b0;
        clear_q();
        repeat (10) step();
        n_cmp++;
        if (q_data.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: got %0d pulses want 0", q_data.size());
        end
        for (int i = 0; i < FL; i++) wr(1000 + i);
        wait_q(FL, ok);
        repeat (5) step();
        n_cmp++;
        if (!ok || q_data.size() != FL) begin
            n_bad++;
            $display("FAIL rstmid_count: got %0d pulses want %0d", q_data.size(), FL);
        end
        for (int i = 0; i < q_data.size() && i < FL; i++) begin
            n_cmp++;
            if (q_data[i] !== mk(1000 + i) || q_last[i] !== (i == FL - 1)) begin
                n_bad++;
                $display("FAIL rstmid_word[%0d]: got %h want %h", i, q_data[i], mk(1000 + i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_toggle();
        test_back_to_back();
        test_overflow();
        test_partial();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/p_frame_fifo.md
Name: p_frame_fifo

Overview:
- Parametrised frame buffer between a pooling layer and the next convolution layer.
- Accepts a serial stream of CH-channel pixel words and stores whole frames of FRAME_LEN words.
- Replays each complete frame word-by-word to the downstream conv layer, throttled by its ready.
- Unlike the fixed 6x16/144 buffer, it generalises width, channel count and frame length, and keeps accepting writes while a frame streams out.
- It also queues multiple complete frames and reports overflow and frame boundaries.

Parameters:
- CH, 6, channels per word.
- DW, 16, bits per channel.
- FRAME_LEN, 144, words per frame; range 2..DEPTH.
- DEPTH, 256, storage words; power of 2, >= FRAME_LEN.
- AW and the counter widths are localparams derived with $clog2: AW = $clog2(DEPTH), count width AW+1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  CH*DW  write word; channel k occupies bits [k*DW +: DW].
- din_valid  in  1  write strobe, one word per cycle.
- out_ready  in  1  downstream (conv) can take a word this cycle.
- dout  out  CH*DW  read word; registered.
- dout_valid  out  1  one-cycle pulse qualifying dout.
- dout_last  out  1  high with dout_valid on the final word of a frame.
- frame_avail  out  1  at least one complete frame stored and not yet fully read.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clock edge): pointers=0, count=0, wr_idx=0, rd_idx=0, frames=0, state=IDLE. dout=0, dout_valid=0, dout_last=0, frame_avail=0, overflow=0. Memory contents are not reset. Reset mid-frame discards all stored and partial data.
- Storage: DEPTH x (CH*DW) inferred RAM with a synchronous read port; no vendor FIFO IP.
- Write:
  - Accepted when din_valid=1 and (count<DEPTH, or a read occurs in the same cycle).
  - On accept: wr_ptr++ (wraps mod DEPTH), wr_idx++.
  - When wr_idx reaches FRAME_LEN-1 on an accept, wr_idx goes to 0 and the frame is complete.
  - Write when full with no simultaneous read: word dropped, wr_idx unchanged, overflow<=1 until rst.
- frames counter (AW+1 bits):
  - +1 on frame completion; -1 on the last read of a frame.
  - Both in the same cycle: unchanged.
  - frame_avail = (frames != 0), registered.
- Read FSM:
  - IDLE: if frames!=0, go to STREAM next cycle. No read occurs in the IDLE cycle.
  - STREAM: a read happens in any cycle with out_ready=1. A read does rd_ptr++ (wraps), rd_idx++, count--.
  - On the read with rd_idx==FRAME_LEN-1: rd_idx<=0, frames--. Go to STREAM if frames (after decrement and any simultaneous increment) is still !=0, else IDLE. Back-to-back frames therefore have no gap cycle.
  - out_ready=0 in STREAM: no read, state held, no timeout.
- Output timing:
  - The read issued in cycle N gives dout valid and dout_valid=1 in cycle N+1.
  - dout_last=1 in N+1 iff the read in N was frame word FRAME_LEN-1.
  - dout_valid is a single-cycle pulse per read; the consumer must capture it (no hold/backpressure on dout).
  - dout keeps its last value when dout_valid=0.
- count: +1 on write accept, -1 on read, unchanged on both. Never exceeds DEPTH and never goes below 0. A read is only issued in STREAM, which implies at least one complete frame is stored.
- A partial frame is never read; words beyond the last complete frame stay until their frame completes.

Optional Feature:
- Macro: P_FRAME_FIFO_LEVEL_EN.
- Defined: extra output ports level [AW:0] (= count, registered) and frames_stored [AW:0] (= frames counter), for debug/UART readout.
- Not defined: the ports do not exist, and nothing else changes.

Test Plan:
- Reset, then 144 writes of CH=6 words with din[k*16+:16] = idx*8+k and out_ready held 1:
  - frame_avail rises 1 cycle after the 144th write; STREAM is entered 1 cycle later.
  - 144 dout_valid pulses follow in order, with dout_last only on word 143 (value 143*8+k).
  - Afterwards frames=0 and state returns to IDLE.
- Same frame with out_ready toggling 1,0,1,0: a dout_valid pulse only in the cycle after each out_ready=1 cycle; data order intact; exactly 144 pulses.
- Write two frames back-to-back (288 writes) with out_ready=1:
  - Frame 2 streams immediately after frame 1's last read with no gap cycle.
  - Frame 2's word 0 is written while frame 1 is streaming.
- DEPTH=256, out_ready=0, 260 writes: the first 256 are stored and writes 257–260 are dropped. overflow=1, count=256, frames=1 (a partial second frame of 112 words).
- Partial frame (100 writes) with out_ready=1: no dout_valid and frame_avail=0. After 44 more writes, the full 144-word frame streams.
- Assert rst for 1 cycle mid-stream (at read word 50): next cycle all outputs=0 and count=0. A subsequent fresh 144-word frame streams correctly from word 0.
